// File: rtl/aes_ctr_stream.sv
// Counter-mode stream wrapper around a fixed-latency, never-stalling AES core.
// Plaintext rides a delay line alongside its counter block, then meets its keystream and lands in an output FIFO.
module aes_ctr_stream #(
    parameter int LATENCY   = 21,
    parameter int OUT_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("OUT_DEPTH must be a power of 2 and at least 2");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be at least 1");
    end

    logic [127:0]       key_q, key_d;
    logic [127:0]       ctr_q, ctr_d;
    logic               keyed_q, keyed_d;
    logic [LATENCY-1:0] dl_v_q, dl_v_d;
    logic [127:0]       dl_pt_q [LATENCY];
    logic [127:0]       dl_pt_d [LATENCY];
    logic [127:0]       fifo_q [OUT_DEPTH];
    logic [127:0]       fifo_d [OUT_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]      inflight_q, inflight_d;

    logic               load_acc;
    logic               fire;
    logic               exit_v;
    logic               pop;
    logic [CW:0]        credit_used;

    // A beat may enter only if a FIFO slot is already reserved for it, because the core cannot be stalled.
    always_comb begin
        credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
        in_ready    = keyed_q && !load && (credit_used < (CW + 1)'(OUT_DEPTH));
        fire        = in_valid && in_ready;
        load_acc    = load && (inflight_q == '0);
        exit_v      = dl_v_q[LATENCY-1];
        out_valid   = (fifo_cnt_q != '0);
        pop         = out_valid && out_ready;
    end

    // NOTE: every signal gets its default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        key_d   = key_q;
        ctr_d   = ctr_q;
        keyed_d = keyed_q;
        if (load_acc) begin
            key_d   = key;
            ctr_d   = iv;
            keyed_d = 1'b1;
        end else if (fire) begin
            ctr_d[31:0] = ctr_q[31:0] + 32'd1;
        end
    end

    // Empty slots carry zero payload so the wide data path stays quiet between beats.
    always_comb begin
        dl_v_d[0]  = fire;
        dl_pt_d[0] = fire ? in_data : '0;
        for (int i = 1; i < LATENCY; i++) begin
            dl_v_d[i]  = dl_v_q[i-1];
            dl_pt_d[i] = dl_pt_q[i-1];
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (exit_v) begin
            fifo_d[wr_ptr_q] = dl_pt_q[LATENCY-1] ^ core_out;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        fifo_cnt_d = fifo_cnt_q + CW'(exit_v) - CW'(pop);
        inflight_d = inflight_q + CW'(fire) - CW'(exit_v);
    end

    // NOTE: the FIFO storage is reset as well so out_data reads zero after reset and no stale block can leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= '0;
            ctr_q      <= '0;
            keyed_q    <= 1'b0;
            dl_v_q     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_pt_q[i] <= '0;
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
        end else begin
            key_q      <= key_d;
            ctr_q      <= ctr_d;
            keyed_q    <= keyed_d;
            dl_v_q     <= dl_v_d;
            dl_pt_q    <= dl_pt_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign core_state = ctr_q;
    assign core_key   = key_q;
    assign out_data   = fifo_q[rd_ptr_q];
    assign busy       = (inflight_q != '0);

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Bench for aes_ctr_stream: stand-in AES core, SP800-38A pairing, handshake/credit scoreboard and directed corners.
module tb_aes_ctr_stream;

    localparam int LAT   = 21;
    localparam int DEPTH = 4;
    localparam int NV    = 8;

    localparam logic [127:0] SP_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] SP_IV1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] SP_PT0  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] SP_PT1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] SP_CT0  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] SP_CT1  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] WRAP_IV = 128'h00000000_00000000_0000000a_ffffffff;
    localparam logic [127:0] WRAP_C1 = 128'h00000000_00000000_0000000a_00000000;

    logic         clk, rst_n, load, in_valid, out_ready;
    logic [127:0] key, iv, in_data;
    logic         in_ready, out_valid, busy;
    logic [127:0] core_state, core_key, core_out, out_data;

    int total = 0;
    int bad   = 0;

    aes_ctr_stream #(.LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .key(key), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in cipher: real keystream for the two SP800-38A blocks, an injective mix elsewhere.
    function automatic logic [127:0] ks_fn(input logic [127:0] k, input logic [127:0] c);
        if (k == SP_KEY && c == SP_IV)  return SP_CT0 ^ SP_PT0;
        if (k == SP_KEY && c == SP_IV1) return SP_CT1 ^ SP_PT1;
        return c ^ {k[95:0], k[127:96]} ^ 128'h0123456789abcdef_fedcba9876543210;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] ctr_add(input logic [127:0] c, input int n);
        return {c[127:32], c[31:0] + 32'(n)};
    endfunction

    // Fixed-latency core: input sampled at an edge, keystream visible LAT-1 edges later.
    logic [127:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= ks_fn(core_key, core_state);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[LAT-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic checkd(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: every accepted beat owes one ciphertext; it is in flight for LAT edges, then buffered.
    logic [127:0] exp_q [$];
    int           exit_q [$];
    int           cyc = 0;
    logic         m_keyed;
    logic [127:0] m_key, m_ctr;
    int           m_out;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        int m_infl;
        m_keyed = 1'b0; m_key = '0; m_ctr = '0; m_out = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exit_q.delete();
                m_keyed = 1'b0; m_key = '0; m_ctr = '0; m_out = 0;
            end else begin
                while (exit_q.size() > 0 && exit_q[0] <= cyc) void'(exit_q.pop_front());
                m_infl = exit_q.size();
                check1("mon_in_ready", in_ready, m_keyed && !load && (m_out < DEPTH));
                check1("mon_out_valid", out_valid, (m_out - m_infl) > 0);
                check1("mon_busy", busy, m_infl != 0);
                check1("mon_credit", m_out <= DEPTH, 1'b1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) checkd("mon_unexpected_out", 1, 0);
                    else check("mon_out_data", out_data, exp_q.pop_front());
                    m_out--;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_data ^ ks_fn(m_key, m_ctr));
                    exit_q.push_back(cyc + 1 + LAT);
                    m_ctr = ctr_add(m_ctr, 1);
                    m_out++;
                end
                if (load && m_infl == 0) begin
                    m_key = key; m_ctr = iv; m_keyed = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_kv(input logic [127:0] k, input logic [127:0] v);
        for (int n = 0; n < 100 && busy; n++) tick();
        load = 1'b1; key = k; iv = v;
        tick();
        load = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] pt, input logic chk, input logic [127:0] ctr, input string name);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = pt;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (chk) check(name, core_state, ctr);
            end
            tick();
        end
        in_valid = 1'b0;
        check1({name, "_accepted"}, ok, 1'b1);
    endtask

    task automatic get_beat(input logic [127:0] exp, input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < LAT + 40 && !ok; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                check(name, out_data, exp);
            end
            tick();
        end
        check1({name, "_seen"}, ok, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check1({name, "_in_ready"}, in_ready, 1'b0);
        check1({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_out_data"}, out_data, '0);
        check1({name, "_busy"}, busy, 1'b0);
        check({name, "_core_state"}, core_state, '0);
        check({name, "_core_key"}, core_key, '0);
    endtask

    typedef struct {
        logic         do_load;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] pt;
        logic [127:0] exp_ct;
        logic [127:0] exp_ctr;
    } vec_t;

    vec_t vt [NV];

    initial begin
        logic [127:0] kk, cc, k1, i1, p, bk, bi, held;
        logic [127:0] bp_pt [6];
        logic [127:0] bp_exp [6];
        int sent, got;

        // SP800-38A pair, a 32-bit counter wrap run, then a random key/iv run.
        vt[0] = '{1'b1, SP_KEY, SP_IV, SP_PT0, SP_CT0, SP_IV};
        vt[1] = '{1'b0, SP_KEY, SP_IV, SP_PT1, SP_CT1, SP_IV1};
        kk = rand128();
        vt[2].pt = rand128();
        vt[2] = '{1'b1, kk, WRAP_IV, vt[2].pt, vt[2].pt ^ ks_fn(kk, WRAP_IV), WRAP_IV};
        vt[3].pt = rand128();
        vt[3] = '{1'b0, kk, WRAP_IV, vt[3].pt, vt[3].pt ^ ks_fn(kk, WRAP_C1), WRAP_C1};
        cc = ctr_add(WRAP_C1, 1);
        vt[4].pt = rand128();
        vt[4] = '{1'b0, kk, WRAP_IV, vt[4].pt, vt[4].pt ^ ks_fn(kk, cc), cc};
        kk = rand128();
        cc = rand128();
        for (int i = 5; i < NV; i++) begin
            vt[i].do_load = (i == 5);
            vt[i].key     = kk;
            vt[i].iv      = cc;
            vt[i].pt      = rand128();
            vt[i].exp_ctr = cc;
            vt[i].exp_ct  = vt[i].pt ^ ks_fn(kk, cc);
            cc = ctr_add(cc, 1);
        end

        rst_n = 1'b0; load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key = '0; iv = '0; in_data = '0;
        #2;
        check_zero("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check1("no_load_in_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vt[i].do_load) load_kv(vt[i].key, vt[i].iv);
            send_beat(vt[i].pt, 1'b1, vt[i].exp_ctr, "vec_ctr");
            get_beat(vt[i].exp_ct, "vec_ct");
        end

        // Single beat: busy for LAT cycles after the accept edge, out_valid from the edge after.
        k1 = rand128(); i1 = rand128(); p = rand128();
        load_kv(k1, i1);
        send_beat(p, 1'b1, i1, "lat_ctr");
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            check1("lat_busy", busy, k < LAT);
            check1("lat_out_valid", out_valid, k == LAT);
        end
        tick();
        get_beat(p ^ ks_fn(k1, i1), "lat_ct");

        // Backpressure: only DEPTH beats may be outstanding while nothing drains.
        bk = rand128(); bi = {rand128()};
        bi[31:0] = 32'h0000_1000;
        for (int i = 0; i < 6; i++) begin
            bp_pt[i]  = rand128();
            bp_exp[i] = bp_pt[i] ^ ks_fn(bk, ctr_add(bi, i));
        end
        load_kv(bk, bi);
        sent = 0; got = 0;
        in_valid = 1'b1; in_data = bp_pt[0];
        for (int n = 0; n < LAT + 20; n++) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            in_valid = (sent < 6);
            in_data  = bp_pt[sent < 6 ? sent : 5];
        end
        checkd("bp_accepted", sent, DEPTH);
        @(negedge clk);
        check1("bp_in_ready", in_ready, 1'b0);
        check1("bp_out_valid", out_valid, 1'b1);
        check("bp_head", out_data, bp_exp[0]);
        for (int n = 0; n < 5; n++) begin
            tick();
            @(negedge clk);
            check("bp_head_stable", out_data, bp_exp[0]);
        end
        tick();
        out_ready = 1'b1;
        for (int n = 0; n < 200 && got < 6; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                check("bp_out", out_data, bp_exp[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            in_valid = (sent < 6);
            in_data  = bp_pt[sent < 6 ? sent : 5];
        end
        checkd("bp_got", got, 6);
        in_valid = 1'b0; out_ready = 1'b0;

        // Load while busy is ignored.
        k1 = rand128(); i1 = rand128(); i1[31:0] = 32'h0000_0100; p = rand128();
        load_kv(k1, i1);
        send_beat(p, 1'b1, i1, "lbusy_ctr0");
        load = 1'b1; key = rand128(); iv = rand128();
        @(negedge clk);
        check1("lbusy_busy", busy, 1'b1);
        tick();
        load = 1'b0;
        @(negedge clk);
        check("lbusy_key", core_key, k1);
        check("lbusy_ctr", core_state, ctr_add(i1, 1));
        tick();
        get_beat(p ^ ks_fn(k1, i1), "lbusy_ct");

        // Load and in_valid together: the beat waits and then uses the new iv.
        k1 = rand128(); i1 = rand128(); p = rand128();
        in_valid = 1'b1; in_data = p; load = 1'b1; key = k1; iv = i1;
        @(negedge clk);
        check1("lvalid_in_ready", in_ready, 1'b0);
        tick();
        load = 1'b0;
        send_beat(p, 1'b1, i1, "lvalid_ctr");
        get_beat(p ^ ks_fn(k1, i1), "lvalid_ct");

        // Random traffic against the scoreboard, with occasional loads (some near a counter wrap).
        load_kv(rand128(), {rand128()});
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rand128();
            out_ready = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 40) == 0);
            key       = rand128();
            iv        = {rand128()};
            if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hffff_fffd;
            tick();
        end
        load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < LAT + 40 && exp_q.size() != 0; n++) tick();
        checkd("rand_drain", exp_q.size(), 0);
        out_ready = 1'b0;

        // Reset with two blocks buffered and two in flight.
        load_kv(rand128(), rand128());
        send_beat(rand128(), 1'b0, '0, "rst_b0");
        send_beat(rand128(), 1'b0, '0, "rst_b1");
        repeat (LAT + 4) tick();
        check1("rst_buffered", out_valid, 1'b1);
        send_beat(rand128(), 1'b0, '0, "rst_b2");
        send_beat(rand128(), 1'b0, '0, "rst_b3");
        check1("rst_inflight", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (2) tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = rand128(); out_ready = 1'b1;
        for (int n = 0; n < LAT + 8; n++) begin
            @(negedge clk);
            check1("rst_after_in_ready", in_ready, 1'b0);
            check1("rst_after_out_valid", out_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        k1 = rand128(); i1 = rand128(); p = rand128();
        load_kv(k1, i1);
        send_beat(p, 1'b1, i1, "rst_new_ctr");
        get_beat(p ^ ks_fn(k1, i1), "rst_new_ct");
        held = out_data;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
